// File: rtl/eprisc_mem_pkg.sv
// eprisc_mem_pkg: owner encoding and default widths shared by the RAM arbiter files
package eprisc_mem_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;
endpackage

// File: rtl/eprisc_arb_pick.sv
// eprisc_arb_pick: combinational two-way picker with owner/burst round-robin or fixed A priority
module eprisc_arb_pick
  import eprisc_mem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  owner_e     owner_i,
  input  logic       burst_max_i,
  input  logic       last_b_i,
  output logic [1:0] gnt_o
);
  logic pref_a;
  // pref_a only matters when both sides request
  always_comb begin
    pref_a = (FIXED_PRIO != 0) ? 1'b1 :
             (owner_i == OWN_NONE) ? last_b_i :
             (owner_i == OWN_A) ? ~burst_max_i : burst_max_i;
    gnt_o[0] = req_a_i & (~req_b_i | pref_a);
    gnt_o[1] = req_b_i & ~gnt_o[0];
  end
endmodule

// File: rtl/eprisc_mem_arbiter.sv
// eprisc_mem_arbiter: shares one single-port registered-read RAM between CPU (A) and loader (B),
// one access per cycle, read data routed back to its issuer one cycle after the ack
module eprisc_mem_arbiter
  import eprisc_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_BURST  = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iReqA,
  input  logic              iWriteA,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [DATA_W-1:0] iDataA,
  output logic              oAckA,
  output logic              oValidA,
  output logic [DATA_W-1:0] oDataA,
  input  logic              iReqB,
  input  logic              iWriteB,
  input  logic [ADDR_W-1:0] iAddrB,
  input  logic [DATA_W-1:0] iDataB,
  output logic              oAckB,
  output logic              oValidB,
  output logic [DATA_W-1:0] oDataB,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  output logic              oMemWrite,
  input  logic [DATA_W-1:0] iMemData
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);
  owner_e owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic last_b_q, last_b_d;
  logic pend_a_q, pend_b_q;
  logic [DATA_W-1:0] data_a_q, data_b_q;
  logic [1:0] gnt_raw, gnt;
  eprisc_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req_a_i    (iReqA),
    .req_b_i    (iReqB),
    .owner_i    (owner_q),
    .burst_max_i(burst_q == BMAX),
    .last_b_i   (last_b_q),
    .gnt_o      (gnt_raw)
  );
  // reset forces every output to its idle value, including the combinational ones
  always_comb begin
    gnt       = iReset ? 2'b00 : gnt_raw;
    oAckA     = gnt[0];
    oAckB     = gnt[1];
    oMemAddr  = gnt[0] ? iAddrA : gnt[1] ? iAddrB : '0;
    oMemData  = gnt[0] ? iDataA : gnt[1] ? iDataB : '0;
    oMemWrite = gnt[0] ? iWriteA : gnt[1] & iWriteB;
    oValidA   = pend_a_q & ~iReset;
    oValidB   = pend_b_q & ~iReset;
    oDataA    = iReset ? '0 : oValidA ? iMemData : data_a_q;
    oDataB    = iReset ? '0 : oValidB ? iMemData : data_b_q;
    owner_d   = gnt[0] ? OWN_A : gnt[1] ? OWN_B : OWN_NONE;
    burst_d   = ~|gnt ? '0 : (owner_d != owner_q) ? BW'(1) :
                (burst_q == BMAX) ? BMAX : burst_q + BW'(1);
    last_b_d  = |gnt ? gnt[1] : last_b_q;
  end
  always_ff @(posedge iClk) begin
    if (iReset) begin
      owner_q  <= OWN_NONE;
      burst_q  <= '0;
      last_b_q <= 1'b1;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      last_b_q <= last_b_d;
      pend_a_q <= gnt[0] & ~iWriteA;
      pend_b_q <= gnt[1] & ~iWriteB;
      data_a_q <= oDataA;
      data_b_q <= oDataB;
    end
  end
endmodule

// File: tb/tb_eprisc_mem_arbiter.sv
// tb_eprisc_mem_arbiter: directed checks of the RAM arbiter, round-robin and fixed-priority builds
module tb_eprisc_mem_arbiter;
  import eprisc_mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic req_a, wr_a, req_b, wr_b;
  logic [7:0] addr_a, addr_b;
  logic [31:0] wd_a, wd_b;
  logic ack_a, ack_b, val_a, val_b, mem_we;
  logic [31:0] rd_a, rd_b, mem_wd, mem_rd;
  logic [7:0] mem_addr;

  logic req_a2, req_b2;
  logic ack_a2, ack_b2, val_a2, val_b2, mem_we2;
  logic [31:0] rd_a2, rd_b2, mem_wd2, mem_rd2;
  logic [7:0] mem_addr2;

  logic [31:0] ram [256];
  logic [31:0] ram2 [256];

  int total = 0;
  int bad = 0;

  eprisc_mem_arbiter #(.MAX_BURST(4), .FIXED_PRIO(0)) dut (
    .iClk(clk), .iReset(rst),
    .iReqA(req_a), .iWriteA(wr_a), .iAddrA(addr_a), .iDataA(wd_a),
    .oAckA(ack_a), .oValidA(val_a), .oDataA(rd_a),
    .iReqB(req_b), .iWriteB(wr_b), .iAddrB(addr_b), .iDataB(wd_b),
    .oAckB(ack_b), .oValidB(val_b), .oDataB(rd_b),
    .oMemAddr(mem_addr), .oMemData(mem_wd), .oMemWrite(mem_we), .iMemData(mem_rd)
  );

  eprisc_mem_arbiter #(.MAX_BURST(4), .FIXED_PRIO(1)) dut2 (
    .iClk(clk), .iReset(rst),
    .iReqA(req_a2), .iWriteA(1'b0), .iAddrA(8'h01), .iDataA(32'h0),
    .oAckA(ack_a2), .oValidA(val_a2), .oDataA(rd_a2),
    .iReqB(req_b2), .iWriteB(1'b0), .iAddrB(8'h02), .iDataB(32'h0),
    .oAckB(ack_b2), .oValidB(val_b2), .oDataB(rd_b2),
    .oMemAddr(mem_addr2), .oMemData(mem_wd2), .oMemWrite(mem_we2), .iMemData(mem_rd2)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wd;
    mem_rd <= ram[mem_addr];
    if (mem_we2) ram2[mem_addr2] <= mem_wd2;
    mem_rd2 <= ram2[mem_addr2];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = 0; wr_a = 0; addr_a = 0; wd_a = 0;
    req_b = 0; wr_b = 0; addr_b = 0; wd_b = 0;
    req_a2 = 0; req_b2 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'h0;
      ram2[i] = 32'h0;
    end
    do_reset();
    @(negedge clk);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_val_a", val_a, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_data_a", rd_a, 0);
    chk("rst_owner", dut.owner_q, OWN_NONE);

    // 1: A write then read back
    cyc();
    req_a = 1; wr_a = 1; addr_a = 8'h10; wd_a = 32'h24413345;
    @(negedge clk);
    chk("t1_wr_ack", ack_a, 1);
    chk("t1_wr_we", mem_we, 1);
    chk("t1_wr_addr", mem_addr, 8'h10);
    chk("t1_wr_data", mem_wd, 32'h24413345);
    cyc();
    wr_a = 0;
    @(negedge clk);
    chk("t1_rd_ack", ack_a, 1);
    chk("t1_rd_we", mem_we, 0);
    chk("t1_wr_noval", val_a, 0);
    cyc();
    idle();
    @(negedge clk);
    chk("t1_val_a", val_a, 1);
    chk("t1_data_a", rd_a, 32'h24413345);
    chk("t1_val_b", val_b, 0);
    chk("t1_idle_addr", mem_addr, 0);
    cyc();
    @(negedge clk);
    chk("t1_val_a_once", val_a, 0);
    chk("t1_data_hold", rd_a, 32'h24413345);

    // 4: B writes, A reads same address next cycle
    cyc();
    req_b = 1; wr_b = 1; addr_b = 8'hFF; wd_b = 32'hDEADBEEF;
    @(negedge clk);
    chk("t4_ack_b", ack_b, 1);
    cyc();
    idle();
    req_a = 1; addr_a = 8'hFF;
    @(negedge clk);
    chk("t4_ack_a", ack_a, 1);
    chk("t4_noval_b", val_b, 0);
    cyc();
    idle();
    @(negedge clk);
    chk("t4_val_a", val_a, 1);
    chk("t4_data_a", rd_a, 32'hDEADBEEF);

    // 3: simultaneous first request, A wins, then B alone
    do_reset();
    req_a = 1; addr_a = 8'h10; req_b = 1; addr_b = 8'hFF;
    @(negedge clk);
    chk("t3_ack_a", ack_a, 1);
    chk("t3_ack_b", ack_b, 0);
    cyc();
    req_a = 0;
    @(negedge clk);
    chk("t3_ack_b2", ack_b, 1);
    chk("t3_ack_a2", ack_a, 0);
    chk("t3_val_a", val_a, 1);
    chk("t3_data_a", rd_a, 32'h24413345);
    cyc();
    req_b = 0;
    @(negedge clk);
    chk("t3_burst", dut.burst_q, 1);
    chk("t3_owner", dut.owner_q, OWN_B);
    chk("t3_val_b", val_b, 1);
    chk("t3_data_b", rd_b, 32'hDEADBEEF);
    chk("t3_val_a_off", val_a, 0);

    // 2: continuous contention -> AAAABBBBAAAA
    do_reset();
    req_a = 1; addr_a = 8'h03; req_b = 1; addr_b = 8'h04;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("t2_ack_a_%0d", i), ack_a, ((i / 4) % 2) == 0);
      chk($sformatf("t2_one_ack_%0d", i), ack_a ^ ack_b, 1);
      cyc();
    end
    idle();

    // 5: reset right after a read ack
    do_reset();
    req_a = 1; addr_a = 8'h10;
    @(negedge clk);
    chk("t5_ack_a", ack_a, 1);
    cyc();
    rst = 1;
    @(negedge clk);
    chk("t5_rst_val_a", val_a, 0);
    chk("t5_rst_ack_a", ack_a, 0);
    chk("t5_rst_data_a", rd_a, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_we", mem_we, 0);
    cyc();
    rst = 0;
    req_a = 0;
    @(negedge clk);
    chk("t5_post_val_a", val_a, 0);
    chk("t5_post_data_a", rd_a, 0);

    // 6: fixed priority build
    do_reset();
    req_a2 = 1; req_b2 = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t6_ack_a_%0d", i), ack_a2, 1);
      chk($sformatf("t6_ack_b_%0d", i), ack_b2, 0);
      cyc();
    end
    req_a2 = 0;
    @(negedge clk);
    chk("t6_b_after", ack_b2, 1);
    chk("t6_a_after", ack_a2, 0);
    cyc();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
